// File: rtl/clkdiv_pkg.sv
// Shared constants for the programmable clock divider: parameter defaults
// and the output-mode encoding.
package clkdiv_pkg;

  localparam int CLKDIV_CNT_W_DEF     = 24;
  localparam int CLKDIV_DIV_RESET_DEF = 5_000_000;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

endpackage : clkdiv_pkg

// File: rtl/prog_clock_divider.sv
// Programmable clock divider: toggle or pulse output, with divisor reloads
// deferred to the period boundary so a running period is never cut short.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int CNT_W      = CLKDIV_CNT_W_DEF,
  parameter int DIV_RESET  = CLKDIV_DIV_RESET_DEF,
  parameter int MODE_RESET = 0
) (
  input  logic             CLK_IN,
  input  logic             RST,
  input  logic             EN,
  input  logic [CNT_W-1:0] DIV_IN,
  input  logic             DIV_LD,
  input  logic             MODE,
  output logic             CLK_OUT,
  output logic             TICK,
  output logic [CNT_W-1:0] DIV_CUR,
  output logic             PENDING
);

  // A zero divisor is meaningless, so it is clamped to 1.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  localparam logic [CNT_W-1:0] DIV_RST_V  = clamp_div(CNT_W'(DIV_RESET));
  localparam logic             MODE_RST_V = (MODE_RESET != 0) ? MODE_PULSE : MODE_TOGGLE;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             mode_q, mode_d;
  logic             term;
  logic [CNT_W-1:0] ld_val;

  assign ld_val = clamp_div(DIV_IN);
  assign term   = EN && (cnt_q == div_cur_q - CNT_W'(1));

  always_comb begin
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_div_d = pend_div_q;
    pending_d  = pending_q;
    mode_d     = mode_q;
    tick_d     = 1'b0;
    clk_out_d  = clk_out_q;

    if (!EN) begin
      // Idle: mode may change freely and a load takes effect immediately.
      mode_d = MODE;
      if (DIV_LD) begin
        div_cur_d = ld_val;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
    end else if (term) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      mode_d = MODE;
      if (DIV_LD) begin
        div_cur_d = ld_val;
        pending_d = 1'b0;
      end else if (pending_q) begin
        div_cur_d = pend_div_q;
        pending_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (DIV_LD) begin
        pend_div_d = ld_val;
        pending_d  = 1'b1;
      end
    end

    // Pulse mode mirrors the tick; entering toggle mode restarts from low.
    if (mode_d == MODE_PULSE) begin
      clk_out_d = tick_d;
    end else if (mode_q == MODE_PULSE) begin
      clk_out_d = 1'b0;
    end else if (term) begin
      clk_out_d = ~clk_out_q;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      cnt_q     <= '0;
      div_cur_q <= DIV_RST_V;
      pending_q <= 1'b0;
      mode_q    <= MODE_RST_V;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  // The stored divisor is only consumed while pending is set.
  always_ff @(posedge CLK_IN) begin
    pend_div_q <= pend_div_d;
  end

  assign CLK_OUT = clk_out_q;
  assign TICK    = tick_q;
  assign DIV_CUR = div_cur_q;
  assign PENDING = pending_q;

endmodule : prog_clock_divider

// File: tb/tb_prog_clock_divider.sv
// Randomized and directed checks of prog_clock_divider against a cycle-level
// reference model built from the divider's behavioural rules.
module tb_prog_clock_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, en, div_ld, mode;
  logic [W-1:0] div_in;
  logic         clk_out, tick, pending;
  logic [W-1:0] div_cur;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_cnt, m_div, m_pdiv;
  bit m_pend, m_mode, m_clk, m_tick;

  prog_clock_divider #(.CNT_W(W), .DIV_RESET(5), .MODE_RESET(0)) dut (
    .CLK_IN (clk),
    .RST    (rst),
    .EN     (en),
    .DIV_IN (div_in),
    .DIV_LD (div_ld),
    .MODE   (mode),
    .CLK_OUT(clk_out),
    .TICK   (tick),
    .DIV_CUR(div_cur),
    .PENDING(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge of the specified behaviour.
  task automatic model_step(input bit r, input bit e, input bit ld, input int din, input bit md);
    int  ldv;
    bit  was_pulse;
    bit  at_end;
    ldv = (din == 0) ? 1 : din;
    if (r) begin
      m_cnt = 0; m_clk = 0; m_tick = 0; m_div = 5; m_pend = 0; m_mode = 0;
      return;
    end
    was_pulse = m_mode;
    if (!e) begin
      m_tick = 0;
      if (ld) begin m_div = ldv; m_cnt = 0; m_pend = 0; end
      m_mode = md;
      if (m_mode || was_pulse) m_clk = 0;
    end else begin
      at_end = (m_cnt == m_div - 1);
      m_tick = at_end;
      if (at_end) begin
        m_cnt  = 0;
        m_mode = md;
        if (ld) begin m_div = ldv; m_pend = 0; end
        else if (m_pend) begin m_div = m_pdiv; m_pend = 0; end
        if (m_mode) m_clk = 1;
        else if (was_pulse) m_clk = 0;
        else m_clk = !m_clk;
      end else begin
        m_cnt = m_cnt + 1;
        if (ld) begin m_pdiv = ldv; m_pend = 1; end
        if (m_mode) m_clk = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance DUT and model, compare all outputs.
  task automatic cyc(input bit r, input bit e, input bit ld, input int din, input bit md);
    @(negedge clk);
    rst = r; en = e; div_ld = ld; div_in = W'(din); mode = md;
    @(posedge clk);
    model_step(r, e, ld, din, md);
    #1;
    chk("clk_out", 32'(clk_out), 32'(m_clk));
    chk("tick",    32'(tick),    32'(m_tick));
    chk("div_cur", 32'(div_cur), 32'(m_div));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  int tick_edges[$];

  initial begin
    rst = 1; en = 0; div_ld = 0; div_in = '0; mode = 0;
    m_pdiv = 1;

    // Reset state against fixed values
    cyc(1, 0, 0, 0, 0);
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_tick",    32'(tick),    0);
    chk("rst_div_cur", 32'(div_cur), 5);
    chk("rst_pending", 32'(pending), 0);

    // Free running: ticks on edges 5, 10, 15; clk_out high over 5..9
    tick_edges.delete();
    for (int i = 1; i <= 15; i++) begin
      cyc(0, 1, 0, 0, 0);
      if (tick) tick_edges.push_back(i);
      if (i == 5) chk("toggle_hi_e5", 32'(clk_out), 1);
      if (i == 10) chk("toggle_lo_e10", 32'(clk_out), 0);
    end
    chk("tick_count", 32'(tick_edges.size()), 3);
    if (tick_edges.size() == 3) begin
      chk("tick_e1", 32'(tick_edges[0]), 5);
      chk("tick_e2", 32'(tick_edges[1]), 10);
      chk("tick_e3", 32'(tick_edges[2]), 15);
    end

    // Deferred load of 3 issued at counter=1
    cyc(0, 1, 0, 0, 0);            // counter 0 -> 1
    cyc(0, 1, 1, 3, 0);            // load while counter=1
    chk("pend_set", 32'(pending), 1);
    chk("pend_div_hold", 32'(div_cur), 5);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);            // terminal edge
    chk("pend_clear", 32'(pending), 0);
    chk("div_now3", 32'(div_cur), 3);
    chk("tick_at_wrap", 32'(tick), 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("tick_after3", 32'(tick), 1);

    // Zero divisor clamps to 1: tick every enabled cycle, clk_out alternates
    cyc(0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    chk("div_zero_is1", 32'(div_cur), 1);
    chk("div1_tick", 32'(tick), 1);

    // Idle-time load applies immediately
    cyc(0, 0, 1, 5, 0);
    chk("idle_ld_div", 32'(div_cur), 5);
    chk("idle_ld_tick", 32'(tick), 0);
    for (int i = 0; i < 12; i++) cyc(0, (i % 4) != 3, 0, 0, 0);

    // Switch to pulse mid-period, then back to toggle
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0);

    // Reset mid-period with a pending load
    cyc(0, 1, 1, 7, 0);
    cyc(1, 1, 1, 2, 1);
    chk("rst2_pending", 32'(pending), 0);
    chk("rst2_div", 32'(div_cur), 5);
    chk("rst2_clk", 32'(clk_out), 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    chk("rst2_first_tick", 32'(tick), 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, e, l, md;
      int d;
      r  = ($urandom_range(0, 99) < 2);
      e  = ($urandom_range(0, 99) < 80);
      l  = ($urandom_range(0, 99) < 8);
      md = ($urandom_range(0, 99) < 50) ? m_mode : !m_mode;
      if ($urandom_range(0, 9) < 7) md = m_mode;
      d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      cyc(r, e, l, d, md);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prog_clock_divider
